// File: rtl/my_spi_regbank.sv
// rtl/my_spi_regbank.sv - SPI mode-0 slave register bank (cfg/status/led + NUM_CH io channels)
// Optional: define MYSPI_FRAMECNT_EN for a read-only frame counter at address 0x03.
`timescale 1ns/1ps
module my_spi_regbank #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 16,
   parameter int NUM_CH   = 19,
   parameter int AUTO_INC = 1
) (
   input  logic                     theClock,
   input  logic                     theReset_n,
   input  logic                     spi_clk,
   input  logic                     spi_cs,
   input  logic                     spi_sdi,
   output logic                     spi_sdo,
   output logic [DATA_W-1:0]        cfg_out,
   input  logic [DATA_W-1:0]        status_in,
   output logic [DATA_W-1:0]        led_out,
   input  logic [NUM_CH*DATA_W-1:0] io_data_in,
   output logic [NUM_CH*DATA_W-1:0] io_data_out,
   output logic [NUM_CH*DATA_W-1:0] io_enable_out,
   output logic [NUM_CH-1:0]        io_wr_strobe,
   output logic                     busy
);

   localparam int HDR_BITS = ADDR_W + 1;
   localparam int CNT_MAX  = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_LO,
      S_HDR_SHIFT,
      S_HDR_HI,
      S_LOAD,
      S_DAT_LO,
      S_DAT_SHIFT,
      S_DAT_HI,
      S_COMMIT
   } state_t;

   state_t state, state_n;

   logic [1:0] clk_sync, cs_sync, sdi_sync;
   logic       clk_prev;
   logic       clk_rise, clk_fall, cs_hi, sdi_s;

   logic [CNT_W-1:0]    bit_cnt;
   logic [HDR_BITS-1:0] hdr_sr;
   logic [DATA_W-1:0]   sr;
   logic [ADDR_W-1:0]   addr;
   logic                wr_flag;

   logic [DATA_W-1:0]        cfg_q, led_q, rd_data;
   logic [NUM_CH*DATA_W-1:0] io_dat_q, io_en_q;
   logic                     wr_cfg, wr_led;
   logic [NUM_CH-1:0]        wr_dat_hit, wr_en_hit;

`ifdef MYSPI_FRAMECNT_EN
   logic              cs_prev;
   logic              frame_used;
   logic [DATA_W-1:0] frame_cnt;
`endif

   // cs synchroniser resets to the deselected level so busy does not blip after reset
   always_ff @(posedge theClock or negedge theReset_n) begin
      if (!theReset_n) begin
         clk_sync <= 2'b00;
         cs_sync  <= 2'b11;
         sdi_sync <= 2'b00;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], spi_clk};
         cs_sync  <= {cs_sync[0], spi_cs};
         sdi_sync <= {sdi_sync[0], spi_sdi};
         clk_prev <= clk_sync[1];
      end
   end

   assign clk_rise = clk_sync[1] & ~clk_prev;
   assign clk_fall = ~clk_sync[1] & clk_prev;
   assign cs_hi    = cs_sync[1];
   assign sdi_s    = sdi_sync[1];

   always_ff @(posedge theClock or negedge theReset_n) begin
      if (!theReset_n) state <= S_IDLE;
      else             state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (!cs_hi) state_n = S_HDR_LO;
         S_HDR_LO:    if (clk_rise) state_n = S_HDR_SHIFT;
         S_HDR_SHIFT: state_n = S_HDR_HI;
         S_HDR_HI:    if (clk_fall)
                         state_n = (bit_cnt == CNT_W'(HDR_BITS)) ? S_LOAD : S_HDR_LO;
         S_LOAD:      state_n = S_DAT_LO;
         S_DAT_LO:    if (clk_rise) state_n = S_DAT_SHIFT;
         S_DAT_SHIFT: state_n = S_DAT_HI;
         S_DAT_HI:    if (clk_fall)
                         state_n = (bit_cnt == CNT_W'(DATA_W)) ? S_COMMIT : S_DAT_LO;
         S_COMMIT:    state_n = S_LOAD;
         default:     state_n = S_IDLE;
      endcase
      if (cs_hi) state_n = S_IDLE;
   end

   always_comb begin
      rd_data    = '0;
      wr_cfg     = (addr == ADDR_W'(0));
      wr_led     = (addr == ADDR_W'(2));
      wr_dat_hit = '0;
      wr_en_hit  = '0;
      if (addr == ADDR_W'(0)) rd_data = cfg_q;
      if (addr == ADDR_W'(1)) rd_data = status_in;
      if (addr == ADDR_W'(2)) rd_data = led_q;
`ifdef MYSPI_FRAMECNT_EN
      if (addr == ADDR_W'(3)) rd_data = frame_cnt;
`endif
      for (int n = 0; n < NUM_CH; n++) begin
         if (addr == ADDR_W'(16 + 2*n)) begin
            rd_data       = io_data_in[n*DATA_W +: DATA_W];
            wr_dat_hit[n] = 1'b1;
         end
         if (addr == ADDR_W'(17 + 2*n)) begin
            rd_data      = io_en_q[n*DATA_W +: DATA_W];
            wr_en_hit[n] = 1'b1;
         end
      end
   end

   always_ff @(posedge theClock or negedge theReset_n) begin
      if (!theReset_n) begin
         bit_cnt <= '0;
         hdr_sr  <= '0;
         sr      <= '0;
         addr    <= '0;
         wr_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               sr      <= '0;
            end
            S_HDR_SHIFT: begin
               hdr_sr  <= {hdr_sr[HDR_BITS-2:0], sdi_s};
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            S_HDR_HI: if (state_n == S_LOAD) begin
               addr    <= hdr_sr[ADDR_W-1:0];
               wr_flag <= hdr_sr[ADDR_W];
            end
            S_LOAD: begin
               sr      <= rd_data;
               bit_cnt <= '0;
            end
            S_DAT_SHIFT: begin
               sr      <= {sr[DATA_W-2:0], sdi_s};
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            S_COMMIT: if (AUTO_INC != 0) addr <= addr + ADDR_W'(1);
            default: ;
         endcase
      end
   end

   // strobe is set up one cycle early so it coincides with COMMIT
   always_ff @(posedge theClock or negedge theReset_n) begin
      if (!theReset_n) begin
         cfg_q        <= '0;
         led_q        <= '0;
         io_dat_q     <= '0;
         io_en_q      <= '0;
         io_wr_strobe <= '0;
      end else begin
         io_wr_strobe <= (state_n == S_COMMIT && wr_flag) ? (wr_dat_hit | wr_en_hit) : '0;
         if (state == S_COMMIT && wr_flag) begin
            if (wr_cfg) cfg_q <= sr;
            if (wr_led) led_q <= sr;
            for (int n = 0; n < NUM_CH; n++) begin
               if (wr_dat_hit[n]) io_dat_q[n*DATA_W +: DATA_W] <= sr;
               if (wr_en_hit[n])  io_en_q[n*DATA_W +: DATA_W]  <= sr;
            end
         end
      end
   end

`ifdef MYSPI_FRAMECNT_EN
   // a word committing in the same cycle cs rise is seen still counts for this frame
   always_ff @(posedge theClock or negedge theReset_n) begin
      if (!theReset_n) begin
         cs_prev    <= 1'b1;
         frame_used <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         cs_prev <= cs_hi;
         if (cs_hi && !cs_prev) begin
            if (frame_used || state == S_COMMIT) frame_cnt <= frame_cnt + DATA_W'(1);
            frame_used <= 1'b0;
         end else if (state == S_COMMIT) begin
            frame_used <= 1'b1;
         end
      end
   end
`endif

   assign spi_sdo       = ~cs_hi & sr[DATA_W-1];
   assign busy          = (state != S_IDLE);
   assign cfg_out       = cfg_q;
   assign led_out       = led_q;
   assign io_data_out   = io_dat_q;
   assign io_enable_out = io_en_q;

endmodule

// File: tb/tb_my_spi_regbank.sv
// tb/tb_my_spi_regbank.sv - directed table-driven bench for my_spi_regbank (default parameters)
`timescale 1ns/1ps
module tb_my_spi_regbank;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int NUM_CH = 19;
   localparam int HALF   = 80;

   logic                     theClock = 1'b0;
   logic                     theReset_n;
   logic                     spi_clk, spi_cs, spi_sdi, spi_sdo;
   logic [DATA_W-1:0]        cfg_out, led_out;
   logic [DATA_W-1:0]        status_in;
   logic [NUM_CH*DATA_W-1:0] io_data_in, io_data_out, io_enable_out;
   logic [NUM_CH-1:0]        io_wr_strobe;
   logic                     busy;

   my_spi_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .AUTO_INC(1)) dut (
      .theClock(theClock), .theReset_n(theReset_n),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
      .cfg_out(cfg_out), .status_in(status_in), .led_out(led_out),
      .io_data_in(io_data_in), .io_data_out(io_data_out), .io_enable_out(io_enable_out),
      .io_wr_strobe(io_wr_strobe), .busy(busy)
   );

   always #5 theClock = ~theClock;

   typedef struct {
      string       name;
      logic        w;
      logic [14:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_sdo;
      logic [15:0] exp_cfg;
      logic [15:0] exp_led;
   } vec_t;

   vec_t              vecs[$];
   logic [NUM_CH-1:0] strobe_log[$];
   logic [15:0]       tx_w[4];
   logic [15:0]       rx_w[4];
   int                total = 0;
   int                bad = 0;

   always @(negedge theClock) if (io_wr_strobe != '0) strobe_log.push_back(io_wr_strobe);

   function automatic vec_t mk(string n, logic w, logic [14:0] a, logic [15:0] wd,
                               logic [15:0] so, logic [15:0] c, logic [15:0] l);
      vec_t v;
      v.name = n; v.w = w; v.addr = a; v.wdata = wd;
      v.exp_sdo = so; v.exp_cfg = c; v.exp_led = l;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bits(input int n, input logic [31:0] v, output logic [31:0] r);
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_sdi = v[i];
         #(HALF);
         r[i] = spi_sdo;
         spi_clk = 1'b1;
         #(HALF);
         spi_clk = 1'b0;
      end
   endtask

   task automatic do_frame(input logic w, input logic [14:0] a, input int nw, input int tail_bits);
      logic [31:0] r;
      spi_cs = 1'b0;
      #(HALF);
      send_bits(16, {16'h0, w, a}, r);
      for (int k = 0; k < nw; k++) begin
         send_bits(16, {16'h0, tx_w[k]}, r);
         rx_w[k] = r[15:0];
      end
      if (tail_bits > 0) send_bits(tail_bits, 32'hFFFF, r);
      #(HALF);
      spi_cs = 1'b1;
      #(4*HALF);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cfg"}, 32'(cfg_out), 32'h0);
      check({tag, "_led"}, 32'(led_out), 32'h0);
      check({tag, "_iodat"}, 32'(io_data_out != '0), 32'h0);
      check({tag, "_ioen"}, 32'(io_enable_out != '0), 32'h0);
      check({tag, "_strobe"}, 32'(io_wr_strobe), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_sdo"}, 32'(spi_sdo), 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      logic [15:0] fc_exp;
      theReset_n = 1'b0;
      spi_clk = 1'b0; spi_cs = 1'b1; spi_sdi = 1'b0;
      status_in = 16'h5A3C;
      for (int n = 0; n < NUM_CH; n++) io_data_in[n*DATA_W +: DATA_W] = 16'hC000 + 16'(n);
      #100;
      check_all_zero("reset");
      theReset_n = 1'b1;
      #100;

`ifdef MYSPI_FRAMECNT_EN
      fc_exp = 16'h000E;
`else
      fc_exp = 16'h0000;
`endif
      vecs.push_back(mk("wr_led",      1, 15'h0002, 16'hA5C3, 16'h0000, 16'h0000, 16'hA5C3));
      vecs.push_back(mk("rd_led",      0, 15'h0002, 16'h0000, 16'hA5C3, 16'h0000, 16'hA5C3));
      vecs.push_back(mk("wr_cfg",      1, 15'h0000, 16'h1234, 16'h0000, 16'h1234, 16'hA5C3));
      vecs.push_back(mk("rd_status",   0, 15'h0001, 16'h0000, 16'h5A3C, 16'h1234, 16'hA5C3));
      vecs.push_back(mk("wr_ro",       1, 15'h0001, 16'hFFFF, 16'h5A3C, 16'h1234, 16'hA5C3));
      vecs.push_back(mk("wr_unmapped", 1, 15'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'hA5C3));
      vecs.push_back(mk("rd_unmapped", 0, 15'h7FFF, 16'h0000, 16'h0000, 16'h1234, 16'hA5C3));
      vecs.push_back(mk("rbw_cfg",     1, 15'h0000, 16'hBEEF, 16'h1234, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("rd_ch1_in",   0, 15'h0012, 16'h0000, 16'hC001, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("rd_ch11_in",  0, 15'h0026, 16'h0000, 16'hC00B, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("wr_ch18_en",  1, 15'h0035, 16'h7777, 16'h0000, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("rd_ch18_en",  0, 15'h0035, 16'h0000, 16'h7777, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("wr_past_ch",  1, 15'h0036, 16'hFFFF, 16'h0000, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("rd_past_ch",  0, 15'h0036, 16'h0000, 16'h0000, 16'hBEEF, 16'hA5C3));
      vecs.push_back(mk("rd_fcnt",     0, 15'h0003, 16'h0000, fc_exp,   16'hBEEF, 16'hA5C3));

      strobe_log.delete();
      foreach (vecs[i]) begin
         tx_w[0] = vecs[i].wdata;
         do_frame(vecs[i].w, vecs[i].addr, 1, 0);
         check({vecs[i].name, "_sdo"}, 32'(rx_w[0]), 32'(vecs[i].exp_sdo));
         check({vecs[i].name, "_cfg"}, 32'(cfg_out), 32'(vecs[i].exp_cfg));
         check({vecs[i].name, "_led"}, 32'(led_out), 32'(vecs[i].exp_led));
      end
      check("table_strobe_count", 32'(strobe_log.size()), 32'd1);
      if (strobe_log.size() > 0) check("table_strobe_ch18", 32'(strobe_log[0]), 32'h40000);
      check("ch18_enable", 32'(io_enable_out[18*DATA_W +: DATA_W]), 32'h7777);
      check("iodat_untouched", 32'(io_data_out != '0), 32'h0);

      // burst write with auto-increment across channel 0 data/enable and channel 1 data
      strobe_log.delete();
      tx_w[0] = 16'h1111; tx_w[1] = 16'h2222; tx_w[2] = 16'h3333;
      do_frame(1'b1, 15'h0010, 3, 0);
      check("burst_sdo0", 32'(rx_w[0]), 32'hC000);
      check("burst_sdo1", 32'(rx_w[1]), 32'h0000);
      check("burst_sdo2", 32'(rx_w[2]), 32'hC001);
      check("burst_ch0_dat", 32'(io_data_out[0 +: DATA_W]), 32'h1111);
      check("burst_ch0_en", 32'(io_enable_out[0 +: DATA_W]), 32'h2222);
      check("burst_ch1_dat", 32'(io_data_out[DATA_W +: DATA_W]), 32'h3333);
      check("burst_strobe_count", 32'(strobe_log.size()), 32'd3);
      if (strobe_log.size() == 3) begin
         check("burst_strobe0", 32'(strobe_log[0]), 32'h1);
         check("burst_strobe1", 32'(strobe_log[1]), 32'h1);
         check("burst_strobe2", 32'(strobe_log[2]), 32'h2);
      end

      // abort after 9 of 16 data bits
      strobe_log.delete();
      spi_cs = 1'b0;
      #(HALF);
      send_bits(16, {16'h0, 1'b1, 15'h0000}, r);
      send_bits(9, 32'hFFFF, r);
      check("abort_busy_before", 32'(busy), 32'h1);
      #(HALF);
      spi_cs = 1'b1;
      repeat (3) @(posedge theClock);
      #5;
      check("abort_busy_after", 32'(busy), 32'h0);
      #(4*HALF);
      check("abort_cfg", 32'(cfg_out), 32'hBEEF);
      check("abort_strobe", 32'(strobe_log.size()), 32'd0);

      // committed word survives a later partial word in the same frame
      tx_w[0] = 16'h1357;
      do_frame(1'b1, 15'h0002, 1, 5);
      check("partial_keep_led", 32'(led_out), 32'h1357);

      // address wraps from the top back to cfg
      do_frame(1'b0, 15'h7FFF, 2, 0);
      check("wrap_word0", 32'(rx_w[0]), 32'h0000);
      check("wrap_word1", 32'(rx_w[1]), 32'hBEEF);

      // reset in the middle of a frame
      spi_cs = 1'b0;
      #(HALF);
      send_bits(16, {16'h0, 1'b1, 15'h0000}, r);
      send_bits(8, 32'hFFFF, r);
      check("midreset_busy_before", 32'(busy), 32'h1);
      theReset_n = 1'b0;
      #30;
      check_all_zero("midreset");
      spi_cs = 1'b1; spi_sdi = 1'b0;
      #50;
      theReset_n = 1'b1;
      #(4*HALF);

      tx_w[0] = 16'h0F0F;
      do_frame(1'b1, 15'h0002, 1, 0);
      check("post_reset_led", 32'(led_out), 32'h0F0F);
      do_frame(1'b0, 15'h0002, 1, 0);
      check("post_reset_rd", 32'(rx_w[0]), 32'h0F0F);
      do_frame(1'b1, 15'h0002, 0, 0);
      tx_w[0] = 16'hFFFF;
      do_frame(1'b1, 15'h0003, 1, 0);
`ifdef MYSPI_FRAMECNT_EN
      check("fcnt_wr_sdo", 32'(rx_w[0]), 32'h0002);
`else
      check("fcnt_wr_sdo", 32'(rx_w[0]), 32'h0000);
`endif
      check("fcnt_wr_cfg", 32'(cfg_out), 32'h0000);
      do_frame(1'b0, 15'h0003, 1, 0);
`ifdef MYSPI_FRAMECNT_EN
      check("fcnt_rd", 32'(rx_w[0]), 32'h0003);
`else
      check("fcnt_rd", 32'(rx_w[0]), 32'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/my_spi_regbank.md
Name: my_spi_regbank

Overview:
Parametrised SPI slave register bank; the next generation of the board's FPGA-side SPI register interface to the host controller. Provides config/LED/status registers plus NUM_CH GPIO channels, each with a data-out, data-in and enable register. Adds to the previous generation:
- configurable widths and channel count
- burst transfers with address auto-increment
- per-channel write strobes
- abort on partial words
- synchronised SDI

Parameters:
ADDR_W, 15, address field width in bits (frame header is ADDR_W+1 bits: R/W flag + address)
DATA_W, 16, register and data-word width
NUM_CH, 19, number of IO channels (1..(2^ADDR_W-16)/2)
AUTO_INC, 1, 1 = address increments after each data word of a frame; 0 = address fixed for the whole frame

Ports:
theClock  in  1  system clock, must be >= 8x spi_clk frequency
theReset_n  in  1  asynchronous active-low reset
spi_clk  in  1  SPI clock, mode 0, idle low
spi_cs  in  1  chip select, active low
spi_sdi  in  1  master-out data, MSB first
spi_sdo  out  1  slave-out data, MSB first
cfg_out  out  DATA_W  config register (addr 0x00, RW)
status_in  in  DATA_W  status value (addr 0x01, RO)
led_out  out  DATA_W  LED register (addr 0x02, RW)
io_data_in  in  NUM_CH*DATA_W  channel input values, channel n at bits [n*DATA_W +: DATA_W]
io_data_out  out  NUM_CH*DATA_W  channel data registers (addr 0x10+2n, write side)
io_enable_out  out  NUM_CH*DATA_W  channel output enables (addr 0x11+2n, RW)
io_wr_strobe  out  NUM_CH  1-cycle pulse when channel n data or enable register is written
busy  out  1  high from CS-fall detection until the FSM returns to IDLE

Behaviour:
- Synchroniser: spi_clk, spi_cs and spi_sdi each pass through 2 flops on theClock. Edges are detected on the synchronised signals. spi_sdi is sampled on the synchronised spi_clk rising edge.
- Async reset: all registers, outputs and counters go to 0; FSM to IDLE; spi_sdo=0.
- Frame layout: header word, then 1..N data words. Header bit ADDR_W is W (1=write); bits [ADDR_W-1:0] are the start address.
- FSM states:
  - IDLE: wait for cs low.
  - HDR_LO: wait for clk rise.
  - HDR_SHIFT (1 cycle): shift in one bit, increment bit counter.
  - HDR_HI: wait for clk fall; after ADDR_W+1 bits go to LOAD, else HDR_LO.
  - LOAD (1 cycle): shift reg <= read value of the current address; bit counter cleared.
  - DAT_LO / DAT_SHIFT / DAT_HI: same pattern as the header, DATA_W bits.
  - COMMIT (1 cycle): if W, write the shift reg to the current address. If AUTO_INC, address <= address+1, wrapping at 2^ADDR_W. Then go to LOAD.
  - Any state: synchronised cs high -> IDLE next cycle (takes priority).
- spi_sdo = shift reg MSB while cs is low, 0 when cs is high. The MSB updates in DAT_SHIFT, before the master's next rising edge.
- Read map:
  - 0x00 cfg
  - 0x01 status_in (captured in LOAD)
  - 0x02 led
  - 0x10+2n io_data_in[n]
  - 0x11+2n io_enable_out[n]
  - unmapped -> all zeros
- Write map: 0x00, 0x02, 0x10+2n, 0x11+2n. Writes to 0x01 or unmapped addresses are ignored, with no strobe.
- Write latency: the target register updates on the clock edge ending COMMIT. io_wr_strobe[n] is high for exactly that COMMIT cycle and is registered.
- Partial word (cs rises before DATA_W bits): word discarded, no write, no strobe. Previously committed words of the frame persist.
- Header-only frame: no access at all.
- Read during write frame: each data word's sdo carries the old value of the address being written, i.e. read-before-write.
- AUTO_INC=0: all words in the frame target the start address; the last complete word wins.
- Address wrap: from 2^ADDR_W-1, the next word targets 0x00.
- cs glitch shorter than 2 theClock cycles: may be ignored by the synchroniser. No requirement on it.

Optional Feature:
MYSPI_FRAMECNT_EN
- Defined: read-only frame counter at address 0x03, DATA_W bits, reset 0. It increments by 1 on each cs rising edge whose frame contained at least one committed data word (read or write), and wraps to 0 after 2^DATA_W-1. Writes to 0x03 are ignored.
- Undefined: address 0x03 is unmapped, reads return 0, and no counter logic is built.

Test Plan:
1. Reset: theReset_n=0 mid-frame -> all outputs 0, busy=0, spi_sdo=0. The next frame after release works normally.
2. Write then read: header W=1 addr 0x02 + word 0xA5C3 -> led_out=0xA5C3, no strobe. Header W=0 addr 0x02 -> sdo shifts 0xA5C3 MSB first.
3. Burst write: AUTO_INC=1, header W=1 addr 0x10, words 0x1111, 0x2222, 0x3333 -> channel 0 data_out=0x1111, channel 0 enable=0x2222, channel 1 data_out=0x3333. io_wr_strobe pulses are bit0, bit0, bit1, one cycle each.
4. Abort: header W=1 addr 0x00, 9 of 16 bits, then cs high -> cfg_out unchanged (0), busy falls within 3 cycles.
5. Unmapped/RO: write 0xFFFF to 0x01 and to 0x7FFF -> no register changes. A read of 0x7FFF returns 0x0000.
6. Wrap plus counter (with MYSPI_FRAMECNT_EN): burst read from 0x7FFF, 2 words -> second word = cfg_out. After 3 complete frames, a read of 0x03 returns 0x0003.
